// File: rtl/dec8_arb_pkg.sv
// Shared types and the rotating priority pick for the 8-way
// round-robin arbiter that drives a 3-to-8 decoder.
package dec8_arb_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Rotate so ptr lands on bit 0, take the lowest set bit,
    // then add ptr back to get the absolute requester index.
    function automatic pick_t rot_pick(
        input logic [N_REQ-1:0] req,
        input logic [IDX_W-1:0] ptr,
        input logic [N_REQ-1:0] mask
    );
        logic [N_REQ-1:0]   live;
        logic [2*N_REQ-1:0] dbl;
        logic [N_REQ-1:0]   rot;
        pick_t              p;
        live = req & ~mask;
        dbl  = {live, live} >> ptr;
        rot  = dbl[N_REQ-1:0];
        p    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                p.found = 1'b1;
                p.idx   = ptr + IDX_W'(k);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first unmasked request
// at or after ptr, wrapping modulo 8.
module rr_pick8
    import dec8_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N_REQ-1:0] mask,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    pick_t p;

    assign p     = rot_pick(req, ptr, mask);
    assign found = p.found;
    assign idx   = p.idx;

endmodule

// File: rtl/dec8_rr_arbiter.sv
// Round-robin arbiter with hold-until-release and a hold limit;
// sel/en feed a 3-to-8 decoder whose output is the grant.
module dec8_rr_arbiter
    import dec8_arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             arb_en,
    output logic [IDX_W-1:0] sel,
    output logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic             en_q, en_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             to_q, to_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic             found;
    logic [IDX_W-1:0] idx;
    logic [N_REQ-1:0] mask;
    logic             take;

    // Masking the current owner only matters on timeout; on
    // release its request bit is already low.
    assign mask = (state_q == GRANT) ? (N_REQ'(1) << sel_q) : '0;

    rr_pick8 u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .mask  (mask),
        .found (found),
        .idx   (idx)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        en_d    = en_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        take    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_en && found) take = 1'b1;
            end
            GRANT: begin
                if (!req[sel_q]) begin
                    if (arb_en && found) begin
                        take = 1'b1;
                    end else begin
                        state_d = IDLE;
                        en_d    = 1'b0;
                        hold_d  = '0;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    if (arb_en && found) begin
                        take = 1'b1;
                        to_d = 1'b1;
                    end else begin
                        hold_d = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: ;
        endcase
        if (take) begin
            state_d = GRANT;
            sel_d   = idx;
            en_d    = 1'b1;
            hold_d  = '0;
            ptr_d   = idx + 1'b1;
        end
        gnt_d = en_d ? (N_REQ'(1) << sel_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= '0;
            en_q    <= 1'b0;
            gnt_q   <= '0;
            to_q    <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign sel     = sel_q;
    assign en      = en_q;
    assign gnt     = gnt_q;
    assign timeout = to_q;

endmodule

// File: tb/tb_dec8_rr_arbiter.sv
// Scoreboard bench: directed steps queue hand-computed outputs,
// a monitor pops one per cycle and cross-checks the decoder.
module tb_dec8_rr_arbiter;

    typedef struct packed {
        logic       en;
        logic [2:0] sel;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       arb_en;
    logic [2:0] sel;
    logic       en;
    logic [7:0] gnt;
    logic       timeout;
    logic [7:0] dec_out;

    exp_t  exp_q[$];
    string nm_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    dec8_rr_arbiter #(
        .MAX_HOLD (4),
        .CNT_W    (8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .arb_en  (arb_en),
        .sel     (sel),
        .en      (en),
        .gnt     (gnt),
        .timeout (timeout)
    );

    function automatic logic [7:0] dec3to8(input logic [2:0] s,
                                           input logic e);
        logic [7:0] o;
        o = '0;
        if (e) o[s] = 1'b1;
        return o;
    endfunction

    assign dec_out = dec3to8(sel, en);

    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [7:0] rq,
                        input logic ae, input logic ee,
                        input logic [2:0] es, input logic et,
                        input string nm);
        exp_t e;
        @(negedge clk);
        rst    = r;
        req    = rq;
        arb_en = ae;
        e.en   = ee;
        e.sel  = es;
        e.to   = et;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    initial begin : monitor
        exp_t       e;
        string      n;
        logic [7:0] eg;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                n  = nm_q.pop_front();
                eg = e.en ? (8'd1 << e.sel) : 8'd0;
                compared++;
                if (en !== e.en || sel !== e.sel || gnt !== eg
                    || timeout !== e.to) begin
                    mismatched++;
                    $display("FAIL %s: got en=%0b sel=%0d gnt=%h to=%0b, want en=%0b sel=%0d gnt=%h to=%0b",
                             n, en, sel, gnt, timeout,
                             e.en, e.sel, eg, e.to);
                end
                compared++;
                if (dec_out !== gnt) begin
                    mismatched++;
                    $display("FAIL %s_dec: decoder=%h gnt=%h",
                             n, dec_out, gnt);
                end
            end
        end
    end

    initial begin : driver
        rst    = 1'b1;
        req    = 8'h00;
        arb_en = 1'b1;

        // reset with all requesting, then first grant to 0
        step(1, 8'hFF, 1, 0, 3'd0, 0, "rst_a");
        step(1, 8'hFF, 1, 0, 3'd0, 0, "rst_b");
        step(0, 8'hFF, 1, 1, 3'd0, 0, "rst_first");
        step(0, 8'h00, 1, 0, 3'd0, 0, "rst_idle");

        // lone requester 5 never times out (ptr=1)
        for (int i = 0; i < 8; i++)
            step(0, 8'h20, 1, 1, 3'd5, 0, "single");
        step(0, 8'h00, 1, 0, 3'd5, 0, "single_rel");

        // 0A from ptr=6: grant 1, drop 1, regrant 3 without bubble
        step(0, 8'h0A, 1, 1, 3'd1, 0, "b2b_g1a");
        step(0, 8'h0A, 1, 1, 3'd1, 0, "b2b_g1b");
        step(0, 8'h08, 1, 1, 3'd3, 0, "b2b_g3");
        step(0, 8'h00, 1, 0, 3'd3, 0, "b2b_rel");

        // timeout rotation between 0 and 7
        step(1, 8'h81, 1, 0, 3'd0, 0, "to_rst");
        for (int i = 0; i < 4; i++)
            step(0, 8'h81, 1, 1, 3'd0, 0, "to_g0");
        for (int i = 0; i < 4; i++)
            step(0, 8'h81, 1, 1, 3'd7, i == 0, "to_g7");
        step(0, 8'h81, 1, 1, 3'd0, 1, "to_back0");
        step(0, 8'h81, 1, 1, 3'd0, 0, "to_hold0");
        step(0, 8'h00, 1, 0, 3'd0, 0, "to_rel");

        // fairness and ptr wrap with everyone requesting
        step(1, 8'hFF, 1, 0, 3'd0, 0, "fair_rst");
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 4; j++)
                step(0, 8'hFF, 1, 1, 3'(k), (k > 0) && (j == 0),
                     "fair");
        step(0, 8'hFF, 1, 1, 3'd0, 1, "fair_wrap");

        // reset mid-grant, then arb_en gating
        step(1, 8'h08, 1, 0, 3'd0, 0, "mid_rst0");
        step(0, 8'h08, 1, 1, 3'd3, 0, "mid_g3");
        step(1, 8'h08, 1, 0, 3'd0, 0, "mid_rst");
        step(0, 8'h10, 0, 0, 3'd0, 0, "arb_off_a");
        step(0, 8'h10, 0, 0, 3'd0, 0, "arb_off_b");
        step(0, 8'h10, 1, 1, 3'd4, 0, "arb_on");

        // ptr must restart at 0 after a mid-grant reset
        step(0, 8'h08, 1, 1, 3'd3, 0, "ptr_g3");
        step(1, 8'h28, 1, 0, 3'd0, 0, "ptr_rst");
        step(0, 8'h28, 1, 1, 3'd3, 0, "ptr_zero");
        // release with arb_en low goes idle, sel held
        step(0, 8'h20, 0, 0, 3'd3, 0, "rel_arb_off");

        @(negedge clk);
        @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
